// File: rtl/dma_streamer.sv
// -----------------------------------------------------------------------------
// dma_streamer
//
// Splits a single DMA descriptor (start address, byte count, INCR/FIXED mode)
// into a sequence of AXI-style burst requests. Each request carries address,
// burst length (alen = beats-1), beat size, byte strobes and the burst mode.
// INCR bursts are clipped so they never cross a 4 KB page. FIXED bursts are
// limited to 16 beats. A trailing partial word goes out as a single-beat
// burst with a partial strobe.
//
// Optional feature (macro DMA_STREAMER_PERF_EN):
//   defined   -> burst_cnt_o counts accepted bursts. It clears on an accepted
//                start and saturates at 0xFFFF.
//   undefined -> burst_cnt_o is tied to zero and no counter exists.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start_i             descriptor launch pulse (honoured only when idle)
//   abort_i             level; no new burst is issued after the pending one
//   desc_addr_i         start byte address
//   desc_bytes_i        total byte count
//   desc_incr_i         1 = INCR, 0 = FIXED
//   req_valid_o         burst request valid
//   req_ready_i         burst request accepted
//   req_addr_o          burst start address
//   req_alen_o          beats - 1
//   req_size_o          log2(DATA_BYTES)
//   req_strb_o          byte strobes
//   req_incr_o          burst mode
//   busy_o              not idle
//   done_o              one-cycle completion pulse
//   err_o               sticky misaligned-start error
//   burst_cnt_o         accepted-burst counter (see macro above)
// -----------------------------------------------------------------------------
module dma_streamer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4,
  parameter int MAX_BEATS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] desc_addr_i,
  input  logic [31:0]           desc_bytes_i,
  input  logic                  desc_incr_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [7:0]            req_alen_o,
  output logic [2:0]            req_size_o,
  output logic [DATA_BYTES-1:0] req_strb_o,
  output logic                  req_incr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           burst_cnt_o
);

  localparam int SIZE = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           rem_bytes;
  logic                  incr_mode;
  logic                  err_q;
  // Remembers an abort seen while a request was stalled, so a short abort
  // pulse still ends the transfer after the pending handshake.
  logic                  abort_pend;

  logic                  start_ok;
  logic                  misaligned;
  logic                  handshake;

  logic [31:0]           full_beats;
  logic [31:0]           page_beats;
  logic [31:0]           beats;
  logic                  tail;
  logic [31:0]           burst_bytes;
  logic [31:0]           rem_nxt;
  logic [7:0]            alen;
  logic [DATA_BYTES-1:0] strb;

  assign start_ok   = (state == ST_IDLE) && start_i;
  assign misaligned = (desc_addr_i & ADDR_WIDTH'(DATA_BYTES - 1)) != '0;
  assign handshake  = (state == ST_REQ) && req_ready_i;

  // ---------------------------------------------------------------------------
  // Burst sizing from registered cur_addr / rem_bytes only, so the payload is
  // stable while the request is stalled.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would infer a latch.
    full_beats  = rem_bytes >> SIZE;
    // Beats left before the next 4 KB page boundary (cur_addr is aligned).
    page_beats  = 32'((13'd4096 - {1'b0, cur_addr[11:0]}) >> SIZE);
    beats       = full_beats;
    tail        = (full_beats == '0);
    burst_bytes = '0;
    alen        = '0;
    strb        = '1;

    if (incr_mode) begin
      if (beats > 32'(MAX_BEATS)) beats = 32'(MAX_BEATS);
      if (beats > page_beats)     beats = page_beats;
    end else begin
      if (beats > 32'd16)         beats = 32'd16;
    end

    if (tail) begin
      // Partial last word: one beat, strobe only the remaining bytes.
      burst_bytes = rem_bytes;
      alen        = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
        strb[i] = (32'(i) < rem_bytes);
      end
    end else begin
      burst_bytes = beats << SIZE;
      alen        = 8'(beats - 32'd1);
    end
  end

  assign rem_nxt = rem_bytes - burst_bytes;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (desc_bytes_i == '0 || misaligned) state_nxt = ST_DONE;
          else                                  state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (handshake && (rem_nxt == '0 || abort_i || abort_pend)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Descriptor / progress registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      rem_bytes  <= '0;
      incr_mode  <= 1'b0;
      err_q      <= 1'b0;
      abort_pend <= 1'b0;
    end else if (start_ok) begin
      cur_addr   <= desc_addr_i;
      rem_bytes  <= desc_bytes_i;
      incr_mode  <= desc_incr_i;
      err_q      <= misaligned;
      abort_pend <= 1'b0;
    end else if (state == ST_REQ) begin
      if (abort_i) abort_pend <= 1'b1;
      if (handshake) begin
        rem_bytes <= rem_nxt;
        // Address wraps naturally modulo 2^ADDR_WIDTH.
        if (incr_mode) cur_addr <= cur_addr + ADDR_WIDTH'(burst_bytes);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: payload is forced to zero outside REQ so reset/idle show zeros.
  // ---------------------------------------------------------------------------
  assign req_valid_o = (state == ST_REQ);
  assign req_addr_o  = req_valid_o ? cur_addr : '0;
  assign req_alen_o  = req_valid_o ? alen : '0;
  assign req_size_o  = req_valid_o ? 3'(SIZE) : '0;
  assign req_strb_o  = req_valid_o ? strb : '0;
  assign req_incr_o  = req_valid_o && incr_mode;
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = (state == ST_DONE);
  assign err_o       = err_q;

`ifdef DMA_STREAMER_PERF_EN
  logic [15:0] burst_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (start_ok) begin
      burst_cnt <= '0;
    end else if (handshake && burst_cnt != 16'hFFFF) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end

  assign burst_cnt_o = burst_cnt;
`else
  assign burst_cnt_o = '0;
`endif

endmodule
